shift_issue: RTL and testbench

- Issue stage directly upstream of the 32-bit shifter in the execute path.
- Accepts decoded R-type shift instructions (funct, instruction shamt field, rs/rt register values) from decode.
- Selects the shift amount source (immediate or register) and encodes the shifter operation.
- Buffers requests in a 2-entry FIFO with valid/ready handshakes on both sides, so decode stalls never corrupt shifter operands.

---
 rtl/shift_issue.sv | 153 +++++++++++++++
 tb/tb_shift_issue.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_issue.sv
// Shift issue stage: decodes R-type shifts, buffers them in a 2-entry FIFO, presents the head to the shifter.
// Latency 1 cycle (no bypass); in_ready depends only on occupancy; optional stall counter via SHIFT_ISSUE_STALL_CNT_EN.

module shift_issue_fifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push_vld,
  output logic         push_rdy,
  input  logic [W-1:0] push_dat,
  output logic         pop_vld,
  input  logic         pop_rdy,
  output logic [W-1:0] pop_dat
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic         push;
  logic         pop;

  // Ready comes from occupancy alone, so a pop never opens room in the same cycle.
  assign push_rdy = (count != 2'd2);
  assign pop_vld  = (count != 2'd0);
  assign push     = push_vld && push_rdy;
  assign pop      = pop_vld && pop_rdy;
  assign pop_dat  = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_dat;
  end

endmodule

module shift_issue #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [5:0]         in_funct,
  input  logic [4:0]         in_shamt,
  input  logic [DATA_W-1:0]  in_rs,
  input  logic [DATA_W-1:0]  in_rt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_op1,
  output logic [SHAMT_W-1:0] out_shamt,
  output logic [1:0]         out_operation,
  output logic               out_illegal
`ifdef SHIFT_ISSUE_STALL_CNT_EN
  ,
  output logic [15:0]        stall_cnt
`endif
);

  typedef struct packed {
    logic               illegal;
    logic [1:0]         operation;
    logic [SHAMT_W-1:0] shamt;
    logic [DATA_W-1:0]  op1;
  } entry_t;

  localparam logic [1:0] OP_SRL = 2'b00;
  localparam logic [1:0] OP_SRA = 2'b01;
  localparam logic [1:0] OP_SLL = 2'b10;
  localparam logic [1:0] OP_BAD = 2'b11;

  entry_t dec_dat;
  entry_t head_dat;

  // Only rs[4:0] feeds variable shifts; the shamt MSB is always zero.
  always_comb begin
    dec_dat           = '0;
    dec_dat.op1       = in_rt;
    dec_dat.operation = OP_BAD;
    dec_dat.illegal   = 1'b0;
    case (in_funct)
      6'h00: begin dec_dat.operation = OP_SLL; dec_dat.shamt = SHAMT_W'(in_shamt);   end
      6'h02: begin dec_dat.operation = OP_SRL; dec_dat.shamt = SHAMT_W'(in_shamt);   end
      6'h03: begin dec_dat.operation = OP_SRA; dec_dat.shamt = SHAMT_W'(in_shamt);   end
      6'h04: begin dec_dat.operation = OP_SLL; dec_dat.shamt = SHAMT_W'(in_rs[4:0]); end
      6'h06: begin dec_dat.operation = OP_SRL; dec_dat.shamt = SHAMT_W'(in_rs[4:0]); end
      6'h07: begin dec_dat.operation = OP_SRA; dec_dat.shamt = SHAMT_W'(in_rs[4:0]); end
      default: begin
        dec_dat.operation = OP_BAD;
        dec_dat.shamt     = '0;
        dec_dat.illegal   = 1'b1;
      end
    endcase
  end

  shift_issue_fifo #(
    .W($bits(entry_t))
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .push_vld (in_valid),
    .push_rdy (in_ready),
    .push_dat (dec_dat),
    .pop_vld  (out_valid),
    .pop_rdy  (out_ready),
    .pop_dat  (head_dat)
  );

  // Empty slots may hold stale data; mask so the shifter sees zeros when idle.
  assign out_op1       = out_valid ? head_dat.op1       : '0;
  assign out_shamt     = out_valid ? head_dat.shamt     : '0;
  assign out_operation = out_valid ? head_dat.operation : 2'b00;
  assign out_illegal   = out_valid ? head_dat.illegal   : 1'b0;

`ifdef SHIFT_ISSUE_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= 16'd0;
    end else if (out_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

  head_stable_a: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready && !flush) |=>
      (out_valid && $stable({out_op1, out_shamt, out_operation, out_illegal})));

endmodule

// File: tb/tb_shift_issue.sv
// Randomized scoreboard bench for shift_issue; reference model is a queue of decoded entries.
module tb_shift_issue;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  in_funct = '0;
  logic [4:0]  in_shamt = '0;
  logic [31:0] in_rs = '0;
  logic [31:0] in_rt = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_op1;
  logic [5:0]  out_shamt;
  logic [1:0]  out_operation;
  logic        out_illegal;
`ifdef SHIFT_ISSUE_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  shift_issue #(.DATA_W(32), .SHAMT_W(6)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_funct      (in_funct),
    .in_shamt      (in_shamt),
    .in_rs         (in_rs),
    .in_rt         (in_rt),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_op1       (out_op1),
    .out_shamt     (out_shamt),
    .out_operation (out_operation),
    .out_illegal   (out_illegal)
`ifdef SHIFT_ISSUE_STALL_CNT_EN
    ,
    .stall_cnt     (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] op1;
    logic [5:0]  shamt;
    logic [1:0]  op;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   sc_model = 0;

  logic m_push = 1'b0, m_pop = 1'b0, m_flush = 1'b0, m_stall = 1'b0;
  exp_t m_new;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode from the instruction mnemonics.
  function automatic exp_t ref_decode(input logic [5:0] f, input logic [4:0] sh,
                                      input logic [31:0] rs, input logic [31:0] rt);
    exp_t e;
    int amt_imm = int'(sh);
    int amt_var = int'(rs) & 31;
    e.op1 = rt;
    e.ill = 1'b0;
    case (f)
      6'h00: begin e.op = 2'b10; e.shamt = 6'(amt_imm); end
      6'h02: begin e.op = 2'b00; e.shamt = 6'(amt_imm); end
      6'h03: begin e.op = 2'b01; e.shamt = 6'(amt_imm); end
      6'h04: begin e.op = 2'b10; e.shamt = 6'(amt_var); end
      6'h06: begin e.op = 2'b00; e.shamt = 6'(amt_var); end
      6'h07: begin e.op = 2'b01; e.shamt = 6'(amt_var); end
      default: begin e.op = 2'b11; e.shamt = 6'd0; e.ill = 1'b1; end
    endcase
    return e;
  endfunction

  // Monitor: compares DUT against model head every cycle, then latches what the next edge will do.
  always @(negedge clk) begin
    check("out_valid", 64'(out_valid), 64'(q.size() != 0));
    check("in_ready", 64'(in_ready), 64'(q.size() < 2));
    if (q.size() != 0) begin
      check("out_op1", 64'(out_op1), 64'(q[0].op1));
      check("out_shamt", 64'(out_shamt), 64'(q[0].shamt));
      check("out_operation", 64'(out_operation), 64'(q[0].op));
      check("out_illegal", 64'(out_illegal), 64'(q[0].ill));
    end else begin
      check("idle_data", {out_op1, 23'd0, out_shamt, out_operation, out_illegal}, 64'd0);
    end
`ifdef SHIFT_ISSUE_STALL_CNT_EN
    check("stall_cnt", 64'(stall_cnt), 64'(sc_model));
`endif
    m_flush = flush;
    m_push  = in_valid && (q.size() < 2);
    m_pop   = out_ready && (q.size() != 0);
    m_stall = !out_ready && (q.size() != 0);
    m_new   = ref_decode(in_funct, in_shamt, in_rs, in_rt);
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      sc_model = 0;
    end else begin
      if (m_stall && sc_model < 65535) sc_model = sc_model + 1;
      if (m_flush) q.delete();
      else begin
        if (m_pop) void'(q.pop_front());
        if (m_push) q.push_back(m_new);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request and hold it until the edge that accepts it.
  task automatic send(input logic [5:0] f, input logic [4:0] sh, input logic [31:0] rs, input logic [31:0] rt);
    int guard = 0;
    in_valid = 1'b1;
    in_funct = f; in_shamt = sh; in_rs = rs; in_rt = rt;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      guard++;
      if (guard > 50) begin
        n_tests++; n_fail++;
        $display("FAIL send_timeout: in_ready stayed 0 expected 1");
        break;
      end
    end
    step();
  endtask

  function automatic logic [5:0] rand_funct();
    logic [5:0] tbl [8] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h01};
    if ($urandom_range(0, 9) == 0) return 6'($urandom);
    return tbl[$urandom_range(0, 7)];
  endfunction

  initial begin
    #1 rst = 1'b1;
    step(); step();
    rst = 1'b0;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_op1", 64'(out_op1), 64'd0);

    // SLL immediate
    send(6'h00, 5'd4, 32'h0, 32'h0000_00F0);
    in_valid = 1'b0;
    check("sll_valid", 64'(out_valid), 64'd1);
    check("sll_op1", 64'(out_op1), 64'h0000_00F0);
    check("sll_shamt", 64'(out_shamt), 64'd4);
    check("sll_op", 64'(out_operation), 64'd2);
    check("sll_ill", 64'(out_illegal), 64'd0);
    out_ready = 1'b1;
    step();

    // SRAV: only rs[4:0] used
    send(6'h07, 5'd17, 32'hFFFF_FFE3, 32'h8000_0000);
    in_valid = 1'b0;
    check("srav_shamt", 64'(out_shamt), 64'd3);
    check("srav_op", 64'(out_operation), 64'd1);
    check("srav_op1", 64'(out_op1), 64'h8000_0000);
    step();

    // Fill under stall; third request held by decode
    out_ready = 1'b0;
    send(6'h02, 5'd1, 32'h0, 32'hAAAA_0001);
    send(6'h03, 5'd2, 32'h0, 32'hAAAA_0002);
    in_funct = 6'h04; in_rs = 32'd9; in_rt = 32'hAAAA_0003;
    check("full_in_ready", 64'(in_ready), 64'd0);
    repeat (3) begin
      step();
      check("full_head", 64'(out_op1), 64'hAAAA_0001);
    end
    out_ready = 1'b1;
    send(6'h04, 5'd0, 32'd9, 32'hAAAA_0003);
    in_valid = 1'b0;
    repeat (4) step();

    // Streaming at occupancy 1: push and pop every cycle
    send(6'h06, 5'd0, 32'd7, 32'h1111_0000);
    for (int i = 1; i <= 5; i++) begin
      send(6'h00, 5'(i), 32'h0, 32'h1111_0000 + i);
      check("stream_in_ready", 64'(in_ready), 64'd1);
    end
    in_valid = 1'b0;
    repeat (3) step();

    // Illegal funct, then flush with a same-cycle push while full
    out_ready = 1'b0;
    send(6'h20, 5'd9, 32'h5, 32'hDEAD_BEEF);
    in_valid = 1'b0;
    check("ill_op", 64'(out_operation), 64'd3);
    check("ill_flag", 64'(out_illegal), 64'd1);
    check("ill_shamt", 64'(out_shamt), 64'd0);
    check("ill_op1", 64'(out_op1), 64'hDEAD_BEEF);
    send(6'h02, 5'd3, 32'h0, 32'h2222_2222);
    flush = 1'b1; in_valid = 1'b1; in_funct = 6'h00; in_rt = 32'h3333_3333;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_valid", 64'(out_valid), 64'd0);
    check("flush_ready", 64'(in_ready), 64'd1);
    step();

    // Asynchronous reset mid-cycle with two entries
    send(6'h03, 5'd5, 32'h0, 32'h4444_0001);
    send(6'h07, 5'd0, 32'd6, 32'h4444_0002);
    in_valid = 1'b0;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_ready", 64'(in_ready), 64'd1);
    step();
    rst = 1'b0;

`ifdef SHIFT_ISSUE_STALL_CNT_EN
    check("sc_zero", 64'(stall_cnt), 64'd0);
    send(6'h00, 5'd1, 32'h0, 32'h5);
    in_valid = 1'b0;
    repeat (10) step();
    check("sc_ten", 64'(stall_cnt), 64'd10);
    #2 rst = 1'b1;
    #1 check("sc_rst", 64'(stall_cnt), 64'd0);
    step();
    rst = 1'b0;
`endif

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_funct  = rand_funct();
      in_shamt  = 5'($urandom);
      in_rs     = $urandom;
      in_rt     = $urandom;
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 29) == 0);
      step();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (4) step();
    check("drained", 64'(out_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
